// File: rtl/halut_result_gather.sv
`default_nettype none
// ============================================================================
// halut_result_gather: captures per-unit decoder results and serialises them
// in strict unit order into a ready/valid FIFO stream.
// Revision: 1.0
// ============================================================================
module halut_result_gather #(
    parameter int DecoderUnits = 16,
    parameter int DataWidth    = 32,
    parameter int FifoDepth    = 4,
    parameter int DecAddrWidth = $clog2(DecoderUnits),
    parameter int CntWidth     = $clog2(FifoDepth + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              en_i,
    input  logic [DecoderUnits*DataWidth-1:0] result_i,
    input  logic [DecoderUnits-1:0]           valid_i,
    output logic [DataWidth-1:0]              data_o,
    output logic [DecAddrWidth-1:0]           m_addr_o,
    output logic                              last_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              row_done_o,
    output logic                              overflow_o,
    output logic [CntWidth-1:0]               fill_o
);

    localparam int PtrWidth = $clog2(FifoDepth);
    localparam logic [DecAddrWidth-1:0] LastUnit  = DecAddrWidth'(DecoderUnits - 1);
    localparam logic [CntWidth-1:0]     FullCount = CntWidth'(FifoDepth);

    logic [DataWidth-1:0]    slot_q [DecoderUnits];
    logic [DecoderUnits-1:0] pending_q;
    logic [DecAddrWidth-1:0] ptr_q;
    logic                    overflow_q;

    logic [DataWidth-1:0]    fifo_data_q [FifoDepth];
    logic [DecAddrWidth-1:0] fifo_addr_q [FifoDepth];
    logic [FifoDepth-1:0]    fifo_last_q;
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [CntWidth-1:0]     count_q;

    logic                    pop;
    logic                    space;
    logic                    push;
    logic                    at_last;
    logic [DecoderUnits-1:0] popped;
    logic [DecoderUnits-1:0] take;
    logic [DecoderUnits-1:0] drop;

    assign pop     = (count_q != '0) && ready_i;
    assign space   = (count_q != FullCount) || pop;
    assign push    = en_i && !flush_i && pending_q[ptr_q] && space;
    assign at_last = (ptr_q == LastUnit);

    always_comb begin
        popped = '0;
        if (push) begin
            popped[ptr_q] = 1'b1;
        end
    end

    // A slot being drained this cycle may be refilled without loss.
    assign take = valid_i & (~pending_q | popped);
    assign drop = valid_i & pending_q & ~popped;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            for (int x = 0; x < DecoderUnits; x++) begin
                slot_q[x] <= '0;
            end
        end else if (flush_i) begin
            pending_q <= '0;
        end else begin
            for (int x = 0; x < DecoderUnits; x++) begin
                if (take[x]) begin
                    slot_q[x]    <= result_i[x*DataWidth +: DataWidth];
                    pending_q[x] <= 1'b1;
                end else if (popped[x]) begin
                    pending_q[x] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                ptr_q <= at_last ? '0 : ptr_q + 1'b1;
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is reset as well so the head outputs read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_last_q <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= slot_q[ptr_q];
                fifo_addr_q[wr_ptr_q] <= ptr_q;
                fifo_last_q[wr_ptr_q] <= at_last;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o     = fifo_data_q[rd_ptr_q];
    assign m_addr_o   = fifo_addr_q[rd_ptr_q];
    assign last_o     = fifo_last_q[rd_ptr_q];
    assign valid_o    = (count_q != '0);
    assign row_done_o = push && at_last;
    assign overflow_o = overflow_q;
    assign fill_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_halut_result_gather.sv
`default_nettype none
// ============================================================================
// tb_halut_result_gather: scenario tasks plus randomized traffic, compared
// cycle by cycle against a queue-based behavioural model.
// Revision: 1.0
// ============================================================================
module tb_halut_result_gather;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int AW = 4;
    localparam int CW = 3;
    localparam int VW = W + AW + CW + 4;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           flush_i = 1'b0;
    logic           en_i = 1'b0;
    logic           ready_i = 1'b0;
    logic [N*W-1:0] result_i = '0;
    logic [N-1:0]   valid_i = '0;
    logic [W-1:0]   data_o;
    logic [AW-1:0]  m_addr_o;
    logic           last_o;
    logic           valid_o;
    logic           row_done_o;
    logic           overflow_o;
    logic [CW-1:0]  fill_o;

    always #5 clk = ~clk;

    halut_result_gather #(
        .DecoderUnits(N),
        .DataWidth   (W),
        .FifoDepth   (D)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .en_i      (en_i),
        .result_i  (result_i),
        .valid_i   (valid_i),
        .data_o    (data_o),
        .m_addr_o  (m_addr_o),
        .last_o    (last_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .row_done_o(row_done_o),
        .overflow_o(overflow_o),
        .fill_o    (fill_o)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [AW-1:0] a;
        logic          l;
    } ent_t;

    // Reference model: slots as arrays, the output FIFO as a queue.
    ent_t         mq[$];
    logic [W-1:0] m_slot[N];
    bit           m_pend[N];
    int           m_ptr;
    bit           m_ovf;

    logic [VW-1:0] obs_vec, exp_vec;
    logic          obs_valid, obs_last, obs_rd, obs_ovf;
    logic [W-1:0]  obs_data;
    logic [AW-1:0] obs_addr;
    logic [CW-1:0] obs_fill;

    function automatic void model_reset();
        mq.delete();
        for (int x = 0; x < N; x++) begin
            m_pend[x] = 0;
            m_slot[x] = '0;
        end
        m_ptr = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_exp();
        bit   ev, pop, push, rd;
        ent_t h;
        ev   = (mq.size() != 0);
        pop  = ev && ready_i;
        push = !flush_i && en_i && m_pend[m_ptr] && (mq.size() < D || pop);
        rd   = push && (m_ptr == N - 1);
        h    = ev ? mq[0] : '0;
        exp_vec = {ev, h.d, h.a, h.l, CW'(mq.size()), m_ovf, rd};
    endfunction

    function automatic void model_step();
        bit pop, push;
        if (flush_i) begin
            for (int x = 0; x < N; x++) m_pend[x] = 0;
            m_ptr = 0;
            mq.delete();
            m_ovf = 0;
            return;
        end
        pop  = (mq.size() != 0) && ready_i;
        push = en_i && m_pend[m_ptr] && (mq.size() < D || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back('{d: m_slot[m_ptr], a: AW'(m_ptr), l: (m_ptr == N - 1)});
            m_pend[m_ptr] = 0;
            m_ptr = (m_ptr + 1) % N;
        end
        for (int x = 0; x < N; x++) begin
            if (valid_i[x]) begin
                if (!m_pend[x]) begin
                    m_slot[x] = result_i[x*W +: W];
                    m_pend[x] = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endfunction

    // One clock: sample at negedge, advance model at posedge, drop strobes.
    task automatic cyc();
        @(negedge clk);
        obs_valid = valid_o;
        obs_data  = valid_o ? data_o : {W{1'b0}};
        obs_addr  = valid_o ? m_addr_o : {AW{1'b0}};
        obs_last  = valid_o & last_o;
        obs_fill  = fill_o;
        obs_ovf   = overflow_o;
        obs_rd    = row_done_o;
        obs_vec   = {obs_valid, obs_data, obs_addr, obs_last, obs_fill, obs_ovf, obs_rd};
        model_exp();
        @(posedge clk);
        model_step();
        #1;
        valid_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic set_result(input int x, input logic [W-1:0] v);
        result_i[x*W +: W] = v;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, data_o, m_addr_o, last_o, row_done_o, overflow_o, fill_o} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h a=%0d l=%b rd=%b o=%b f=%0d want all 0",
                     valid_o, data_o, m_addr_o, last_o, row_done_o, overflow_o, fill_o);
        end
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ordered_row();
        int first = -1, nbeat = 0, nrd = 0;
        en_i = 1'b1;
        ready_i = 1'b1;
        for (int x = 0; x < N; x++) set_result(x, 32'h3F80_0000 + x);
        valid_i = '1;
        for (int c = 0; c < 24; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL row_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_valid && first < 0) first = c;
            if (obs_rd) nrd++;
            if (obs_valid) begin
                checks++;
                if (obs_addr !== AW'(nbeat) || obs_data !== 32'h3F80_0000 + nbeat
                    || obs_last !== (nbeat == N - 1)) begin
                    errors++;
                    $display("FAIL row_beat %0d got a=%0d d=%h l=%b want a=%0d d=%h",
                             nbeat, obs_addr, obs_data, obs_last, nbeat, 32'h3F80_0000 + nbeat);
                end
                nbeat++;
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL row_latency got %0d want 2", first);
        end
        checks++;
        if (nbeat != N || nrd != 1) begin
            errors++;
            $display("FAIL row_count got beats=%0d row_done=%0d want 16 and 1", nbeat, nrd);
        end
    endtask

    task automatic test_out_of_order();
        logic [W-1:0] dv[4];
        int n = 0;
        do_flush();
        en_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        set_result(3, dv[3]);
        valid_i[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec || obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL ooo_early c%0d got=%h want=%h (valid 0)", c, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 3; i++) set_result(i, dv[i]);
        valid_i[2:0] = 3'b111;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL ooo_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_valid) begin
                checks++;
                if (n > 3 || obs_addr !== AW'(n) || obs_data !== dv[n]) begin
                    errors++;
                    $display("FAIL ooo_beat %0d got a=%0d d=%h", n, obs_addr, obs_data);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL ooo_count got %0d want 4", n);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] dv[N];
        int n = 0;
        do_flush();
        en_i = 1'b1;
        ready_i = 1'b0;
        for (int x = 0; x < N; x++) begin
            dv[x] = $urandom;
            set_result(x, dv[x]);
        end
        valid_i = '1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_fill !== CW'(4) || obs_valid !== 1'b1 || obs_data !== dv[0] || obs_addr !== '0) begin
            errors++;
            $display("FAIL bp_stall got f=%0d v=%b d=%h a=%0d want f=4 v=1 d=%h a=0",
                     obs_fill, obs_valid, obs_data, obs_addr, dv[0]);
        end
        ready_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_drain c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_valid) begin
                checks++;
                if (n >= N || obs_addr !== AW'(n) || obs_data !== dv[n]) begin
                    errors++;
                    $display("FAIL bp_beat %0d got a=%0d d=%h", n, obs_addr, obs_data);
                end
                n++;
            end
        end
        checks++;
        if (n != N || obs_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_total got beats=%0d ovf=%b want 16 and 0", n, obs_ovf);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        logic [W-1:0] got2 = '0;
        do_flush();
        en_i = 1'b0;
        ready_i = 1'b1;
        set_result(2, 32'hAAAA_0000);
        valid_i[2] = 1'b1;
        cyc();
        set_result(2, 32'hBBBB_0000);
        valid_i[2] = 1'b1;
        cyc();
        cyc();
        checks++;
        if (obs_ovf !== 1'b1 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL ovf_flag got ovf=%b vec=%h want ovf=1 vec=%h", obs_ovf, obs_vec, exp_vec);
        end
        en_i = 1'b1;
        set_result(0, $urandom);
        set_result(1, $urandom);
        valid_i[1:0] = 2'b11;
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL ovf_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_valid) begin
                if (n == 2) got2 = obs_data;
                n++;
            end
        end
        checks++;
        if (n != 3 || got2 !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL ovf_keep got beats=%0d unit2=%h want 3 and aaaa0000", n, got2);
        end
    endtask

    task automatic test_recapture();
        int n = 0;
        logic [W-1:0] last0 = '0;
        do_flush();
        en_i = 1'b1;
        ready_i = 1'b1;
        set_result(0, 32'h1);
        valid_i[0] = 1'b1;
        cyc();
        set_result(0, 32'h2);
        valid_i[0] = 1'b1;
        cyc();
        for (int x = 1; x < N; x++) set_result(x, $urandom);
        valid_i = 16'hFFFE;
        for (int c = 0; c < 24; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL recap_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
            if (obs_valid) begin
                if (n == N) last0 = obs_data;
                n++;
            end
        end
        checks++;
        if (n != N + 1 || last0 !== 32'h2 || obs_ovf !== 1'b0) begin
            errors++;
            $display("FAIL recap got beats=%0d wrap_d=%h ovf=%b want 17, 2, 0", n, last0, obs_ovf);
        end
    endtask

    // Leaves three entries stalled in the FIFO with overflow set.
    task automatic fill_three(input string tag);
        int c = 0;
        do_flush();
        en_i = 1'b1;
        ready_i = 1'b0;
        for (int x = 0; x < N; x++) set_result(x, $urandom);
        valid_i = 16'h0207;
        cyc();
        valid_i[9] = 1'b1;
        cyc();
        while (obs_fill !== CW'(3) && c < 10) begin
            cyc();
            c++;
        end
        checks++;
        if (obs_fill !== CW'(3) || obs_ovf !== 1'b1 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL %s_setup got f=%0d ovf=%b vec=%h want f=3 ovf=1 vec=%h",
                     tag, obs_fill, obs_ovf, obs_vec, exp_vec);
        end
    endtask

    task automatic next_row_check(input string tag);
        int first = -1;
        ready_i = 1'b1;
        for (int x = 0; x < N; x++) set_result(x, $urandom);
        valid_i = '1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL %s_row c%0d got=%h want=%h", tag, c, obs_vec, exp_vec);
            end
            if (obs_valid && first < 0) begin
                first = c;
                checks++;
                if (obs_addr !== '0) begin
                    errors++;
                    $display("FAIL %s_first_addr got %0d want 0", tag, obs_addr);
                end
            end
        end
    endtask

    task automatic test_flush();
        fill_three("flush");
        flush_i = 1'b1;
        valid_i = '1;
        cyc();
        cyc();
        checks++;
        if (obs_valid !== 1'b0 || obs_fill !== '0 || obs_ovf !== 1'b0 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL flush_clear got v=%b f=%0d ovf=%b want 0 0 0", obs_valid, obs_fill, obs_ovf);
        end
        next_row_check("flush");
    endtask

    task automatic test_async_reset();
        fill_three("arst");
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || fill_o !== '0 || overflow_o !== 1'b0 || row_done_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear got v=%b f=%0d ovf=%b rd=%b want 0", valid_o, fill_o, overflow_o, row_done_o);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        next_row_check("arst");
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 400; c++) begin
            en_i    = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 63) == 0);
            valid_i = N'($urandom & $urandom & $urandom);
            for (int x = 0; x < N; x++) set_result(x, $urandom);
            cyc();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rand_model c%0d got=%h want=%h", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ordered_row();
        test_out_of_order();
        test_backpressure();
        test_overflow();
        test_recapture();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/halut_result_gather.md
Name: halut_result_gather

Overview:
- Collects FP32 results from an array of DecoderUnits HALUT decoder units and serialises them into one ready/valid output stream.
- Outputs are in strict M order (unit 0..DecoderUnits-1, then wrap).
- Successor to the single-pointer gather stage: adds per-unit capture slots, an output FIFO with backpressure, flush, row-boundary marking and overflow detection.
- Sits between the decoder array and the accumulation/writeback path.

Parameters:
DecoderUnits, 16, number of decoder units feeding the block; must be ≥2.
DataWidth, 32, result word width (FP32 by default).
FifoDepth, 4, output FIFO entries; power of two, ≥2.
DecAddrWidth, $clog2(DecoderUnits), unit index width.
CntWidth, $clog2(FifoDepth+1), FIFO fill-count width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
flush_i  in  1  synchronous clear of slots, FIFO and scan pointer
en_i  in  1  scanner enable (decoding active)
result_i  in  DecoderUnits*DataWidth  unit x result at bits [x*DataWidth +: DataWidth]
valid_i  in  DecoderUnits  per-unit single-cycle result strobe
data_o  out  DataWidth  FIFO head result
m_addr_o  out  DecAddrWidth  unit index of FIFO head
last_o  out  1  head entry came from unit DecoderUnits-1
valid_o  out  1  FIFO non-empty
ready_i  in  1  downstream accept
row_done_o  out  1  one-cycle pulse when the scanner pushes unit DecoderUnits-1
overflow_o  out  1  sticky: a result was dropped
fill_o  out  CntWidth  current FIFO occupancy

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. Reset clears all slots' pending bits, the scan pointer, the FIFO pointers and count, and overflow. All outputs read 0.
- Capture slots, one per unit:
  - valid_i[x]=1 captures result_i slice x into slot x and sets pending[x].
  - Captures happen regardless of en_i.
- Overflow on a slot:
  - If valid_i[x]=1 while pending[x]=1 and slot x is not being popped this cycle: new data is dropped, slot keeps the old data, overflow_o is set.
  - If slot x is popped in the same cycle: new data is captured, pending stays 1, no overflow.
- Scanner:
  - Pointer ptr starts at 0.
  - Push condition, in one cycle: en_i=1, pending[ptr]=1 and FIFO has space. Then {slot[ptr], ptr, ptr==DecoderUnits-1} is pushed, pending[ptr] is cleared and ptr advances.
  - ptr wraps from DecoderUnits-1 to 0; row_done_o pulses in the same cycle as that push.
  - Strict order: if pending[ptr]=0, ptr waits. Later units are never skipped ahead.
  - en_i=0 freezes ptr and performs no push.
- FIFO space: count<FifoDepth, or count==FifoDepth and a pop occurs this cycle (push and pop when full are both allowed).
- Output handshake:
  - Pop occurs when valid_o && ready_i.
  - data_o, m_addr_o and last_o come straight from registered FIFO storage at the read pointer.
  - They stay stable while valid_o=1 and ready_i=0.
  - Empty FIFO: valid_o=0 and data_o is don't-care.
- Latency:
  - valid_i[x] at cycle t (ptr==x, en_i, space) → pending at t+1 → push at t+1 → valid_o=1 at t+2.
  - Minimum 2 cycles; throughput is 1 result/cycle.
- Simultaneous push+pop: count unchanged, both pointers advance.
- flush_i=1, which has priority over everything except reset:
  - Next cycle: pending all 0, ptr=0, FIFO empty, overflow_o=0.
  - valid_i in the flush cycle is ignored.
  - No row_done_o pulse.
- Reset mid-stream: all state is lost immediately. No partial output is held.
- fill_o equals the FIFO entry count. Pointers use DecAddrWidth/log2(FifoDepth) bits with natural wrap.

Test Plan:
- Ordered row:
  - Stimulus: DecoderUnits=16, en_i=1, ready_i=1, valid_i all 16 bits in one cycle, result x = 0x3F800000+x.
  - Required: 16 beats m_addr_o=0..15 with matching data; last_o and row_done_o only for unit 15; first valid_o 2 cycles after the strobe.
- Out-of-order arrival:
  - Stimulus: unit 3 strobes, then 5 cycles later units 0,1,2.
  - Required: nothing is output before unit 0; then order 0,1,2,3.
- Backpressure:
  - Stimulus: FifoDepth=4, ready_i=0, all units strobe.
  - Required: fill_o=4, ptr stalls at 4, valid_o held with data_o=unit 0, pending[4..15]=1.
  - Then ready_i=1 drains all 16 in order with no loss and overflow_o=0.
- Overflow:
  - Stimulus: en_i=0, unit 2 strobes 0xAAAA0000 then 0xBBBB0000.
  - Required: overflow_o=1. After en_i=1 with units 0,1 supplied, unit 2 outputs 0xAAAA0000.
- Same-cycle pop and re-capture:
  - Stimulus: unit 0 strobes 0x1, then strobes 0x2 in the cycle it is pushed.
  - Required: overflow_o=0; unit 0's second value appears after the wrap.
- Flush and reset:
  - Stimulus: flush_i mid-row with fill_o=3.
  - Required: next cycle valid_o=0, fill_o=0, overflow_o=0; the next row starts at m_addr_o=0.
  - Repeat with rst_ni pulsed low asynchronously: same result.
